// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues word fetches to a one-cycle
// memory, buffers returns in a small FIFO and hands them downstream via valid/ready.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 3,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [31:0]      imem_addr,
    output logic             imem_en,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [31:0]      inst_pc,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
    localparam logic [OccW:0] DepthCnt = (OccW + 1)'(BUF_DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      issue_pc_q;
    logic             inflight_q;
    logic [31:0]      buf_data_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q   [BUF_DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [OccW-1:0]  occ_q;
    logic [CNT_W-1:0] fetch_cnt_q;

    logic             issue;
    logic             flush;
    logic             push;
    logic             pop;
    logic [OccW:0]    credit;
    logic             unused_redirect_lsbs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Buffered words plus the one in flight must never exceed the FIFO depth.
    assign credit = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q};
    assign issue  = (state_q == StRun) && !redirect_valid && (credit < DepthCnt);
    // In IDLE a redirect only retargets the PC; buffered words are kept.
    assign flush  = redirect_valid && (state_q == StRun);
    assign push   = inflight_q && !flush;
    assign pop    = inst_valid && inst_ready;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            issue_pc_q  <= RESET_PC;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            fetch_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle:  if (run)  state_q <= StRun;
                StRun:   if (!run) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (redirect_valid) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end

            inflight_q <= issue;
            if (issue) begin
                issue_pc_q <= pc_q;
            end

            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end

            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push, pop})
                    2'b10:   occ_q <= occ_q + 1'b1;
                    2'b01:   occ_q <= occ_q - 1'b1;
                    default: occ_q <= occ_q;
                endcase
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]   <= issue_pc_q;
        end
    end

    assign imem_addr  = {pc_q[31:2], 2'b00};
    assign imem_en    = issue;
    assign inst_valid = (occ_q != '0);
    assign inst_data  = buf_data_q[rd_ptr_q];
    assign inst_pc    = buf_pc_q[rd_ptr_q];
    assign busy       = inst_valid || inflight_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch sequencer in front of the instruction memory (1024 x 32-bit words, one-cycle registered read, byte address in, word out). Owns the PC, issues one word-aligned fetch address per cycle, absorbs the memory's read latency with a small FIFO, and presents instructions downstream with a valid/ready handshake. Handles downstream back-pressure, redirects (jump/branch) with squashing of stale fetches, and run/halt control.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
BUF_DEPTH, 3, instruction FIFO entries; legal minimum 3 (full throughput needs 3)
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
run  in  1  1 = fetch enabled; 0 = stop issuing (drain only)
imem_addr  out  32  byte address to instruction memory; always {pc[31:2],2'b00}
imem_en  out  1  issue strobe; 1 = imem_addr is a real fetch this cycle
imem_rdata  in  32  memory read data; valid the cycle after an issue
redirect_valid  in  1  load new PC this cycle
redirect_pc  in  32  redirect target; bits [1:0] ignored
inst_valid  out  1  FIFO head valid
inst_ready  in  1  consumer accepts head when inst_valid & inst_ready
inst_data  out  32  head instruction word
inst_pc  out  32  byte address the head was fetched from
busy  out  1  1 when FIFO non-empty or a fetch is in flight
fetch_cnt  out  CNT_W  count of accepted instructions (wraps)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pc=RESET_PC, FIFO empty, in-flight flag cleared, fetch_cnt=0. Outputs after reset: inst_valid=0, imem_en=0, busy=0, imem_addr=RESET_PC. Reset mid-operation discards all buffered and in-flight words; the late memory return is never captured.
- FSM: IDLE -> RUN when run=1 sampled; RUN -> IDLE when run=0 sampled. In IDLE no issue; FIFO still drains and the in-flight word is still captured.
- Issue (cycle t): imem_en = (state==RUN) & ~redirect_valid & (occ + inflight < BUF_DEPTH). occ = FIFO count at start of t; inflight = 1 iff issued in t-1. On issue: pc <= pc+4 (wraps at 2^32), inflight <= 1, record issue PC.
- Return: word issued in t appears on imem_rdata in t+1 and is written to the FIFO at the end of t+1 with its PC. inst_valid is first high in t+2. Issue-to-valid latency 2 cycles; with inst_ready=1 the throughput is 1 instr/cycle after the first.
- Credit rule guarantees no overflow: a write never occurs into a full FIFO. Simultaneous push and pop in the same cycle are legal and leave occ unchanged.
- Downstream: inst_data/inst_pc hold stable while inst_valid=1 and inst_ready=0. No drop, no duplicate.
- Redirect (redirect_valid=1 at edge of t): pc <= {redirect_pc[31:2],2'b00}; FIFO flushed; an in-flight word (issued t-1, returning in t) is dropped; no issue in t. A handshake at the head in cycle t still completes and is counted. The first issue of the target occurs in t+1, and its inst_valid appears in t+3. Redirect has priority over run=0 for the PC load. In IDLE, the redirect loads pc only.
- fetch_cnt increments by 1 per inst_valid & inst_ready and wraps to 0.
- busy = (occ != 0) | inflight.

Test Plan:
- Reset, mem[k]=k-th word, run=1, ready=1 -> imem_addr 0,4,8,... one per cycle; inst_valid first at cycle 2 after first issue; inst_pc 0,4,8 with inst_data mem[0],mem[1],mem[2]; fetch_cnt=10 after 10 accepts.
- ready=0 for 5 cycles mid-stream -> imem_en falls once occ+inflight=3; FIFO holds 3 words with head stable; after release, the sequence continues with no gap or duplicate.
- redirect_pc=0x43 while FIFO holds 3 and a fetch is in flight -> next issue at 0x40; no stale word is delivered; the next accepted inst_pc is 0x40, 3 cycles after the redirect.
- Redirect in the same cycle as a head handshake -> that instruction is counted; everything behind it is flushed.
- run=0 mid-stream -> issue stops next cycle; in-flight word and FIFO drain; busy falls; run=1 resumes at the next sequential PC.
- rst pulse with FIFO full and ready=0 -> next cycle inst_valid=0, fetch_cnt=0, imem_addr=RESET_PC; the stray return is not captured.
